// File: rtl/sequenciador_ram64_pkg.sv
// Shared constants, state encoding and length clamp for the RAM64 sequencer.
package sequenciador_ram64_pkg;

  localparam int LARGURA          = 16;
  localparam int BITS_ENDERECO    = 6;
  localparam int BITS_COMPRIMENTO = 7;
  localparam int PROFUNDIDADE     = 64;

  // Longest useful operation: one pass over every RAM word.
  localparam logic [BITS_COMPRIMENTO-1:0] COMPRIMENTO_MAX = 7'd64;

  typedef enum logic [1:0] {
    OCIOSO     = 2'd0,
    EXECUTANDO = 2'd1,
    CONCLUIDO  = 2'd2
  } estado_t;

  // Lengths beyond the RAM depth would only revisit words, so cap them.
  function automatic logic [BITS_COMPRIMENTO-1:0] limitar_comprimento(
    input logic [BITS_COMPRIMENTO-1:0] c
  );
    return (c > COMPRIMENTO_MAX) ? COMPRIMENTO_MAX : c;
  endfunction

endpackage

// File: rtl/contador_endereco_wrap.sv
// Loadable RAM address register; increments wrap naturally from 63 to 0.
module contador_endereco_wrap
  import sequenciador_ram64_pkg::*;
(
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_carregar,
  input  logic [BITS_ENDERECO-1:0] i_valor,
  input  logic                     i_incrementar,
  output logic [BITS_ENDERECO-1:0] o_endereco
);

  logic [BITS_ENDERECO-1:0] r_endereco;

  // Load has priority over increment; the width provides the modulo-64 wrap.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_endereco <= '0;
    end else if (i_carregar) begin
      r_endereco <= i_valor;
    end else if (i_incrementar) begin
      r_endereco <= r_endereco + 1'b1;
    end
  end

  assign o_endereco = r_endereco;

endmodule

// File: rtl/sequenciador_ram64.sv
// Command sequencer owning the RAM64 ports: fills a wrapping address range
// with an arithmetic sequence, or reads it back into a 16-bit checksum.
module sequenciador_ram64
  import sequenciador_ram64_pkg::*;
(
  input  logic                        clock_principal,
  input  logic                        reset,
  input  logic                        iniciar,
  input  logic                        modo,
  input  logic [BITS_ENDERECO-1:0]    endereco_base,
  input  logic [BITS_COMPRIMENTO-1:0] comprimento,
  input  logic [LARGURA-1:0]          valor_inicial,
  input  logic [LARGURA-1:0]          passo,
  input  logic [LARGURA-1:0]          dados_saida_ram,
  output logic [LARGURA-1:0]          dados_entrada_ram,
  output logic [BITS_ENDERECO-1:0]    endereco_ram,
  output logic                        write_ram,
  output logic                        ocupado,
  output logic                        concluido,
  output logic [LARGURA-1:0]          soma
);

  estado_t                     r_estado;
  logic                        r_modo;
  logic [LARGURA-1:0]          r_dados;
  logic [LARGURA-1:0]          r_passo;
  logic [BITS_COMPRIMENTO-1:0] r_contador;
  logic [LARGURA-1:0]          r_soma;

  logic                        w_aceitar;
  logic                        w_executando;
  logic [BITS_COMPRIMENTO-1:0] w_comprimento;
  logic [BITS_ENDERECO-1:0]    w_endereco;

  assign w_aceitar     = (r_estado == OCIOSO) && iniciar;
  assign w_executando  = (r_estado == EXECUTANDO);
  assign w_comprimento = limitar_comprimento(comprimento);

  contador_endereco_wrap u_endereco (
    .i_clk         (clock_principal),
    .i_rst         (reset),
    .i_carregar    (w_aceitar),
    .i_valor       (endereco_base),
    .i_incrementar (w_executando),
    .o_endereco    (w_endereco)
  );

  // Control FSM plus data/step accumulator and checksum; one word per cycle.
  always_ff @(posedge clock_principal or posedge reset) begin
    if (reset) begin
      r_estado   <= OCIOSO;
      r_modo     <= 1'b0;
      r_dados    <= '0;
      r_passo    <= '0;
      r_contador <= '0;
      r_soma     <= '0;
    end else begin
      case (r_estado)
        OCIOSO: begin
          if (iniciar) begin
            r_modo     <= modo;
            r_dados    <= valor_inicial;
            r_passo    <= passo;
            r_contador <= w_comprimento;
            r_soma     <= '0;
            r_estado   <= (w_comprimento != '0) ? EXECUTANDO : CONCLUIDO;
          end
        end
        EXECUTANDO: begin
          if (r_modo) begin
            r_soma <= r_soma + dados_saida_ram;
          end
          r_dados    <= r_dados + r_passo;
          r_contador <= r_contador - 1'b1;
          if (r_contador == 7'd1) begin
            r_estado <= CONCLUIDO;
          end
        end
        CONCLUIDO: begin
          r_estado <= OCIOSO;
        end
        default: begin
          r_estado <= OCIOSO;
        end
      endcase
    end
  end

  // Strobes decode straight from the state register, so an async reset
  // drops write_ram without waiting for a clock edge.
  assign ocupado           = w_executando;
  assign write_ram         = w_executando && !r_modo;
  assign concluido         = (r_estado == CONCLUIDO);
  assign endereco_ram      = w_endereco;
  assign dados_entrada_ram = r_dados;
  assign soma              = r_soma;

endmodule

// File: tb/tb_sequenciador_ram64.sv
// Randomized self-checking bench for sequenciador_ram64 with a behavioural
// RAM and a range-level reference model of fill/checksum operations.
module tb_sequenciador_ram64;

  logic        clock_principal = 1'b0;
  logic        reset = 1'b1;
  logic        iniciar = 1'b0;
  logic        modo = 1'b0;
  logic [5:0]  endereco_base = '0;
  logic [6:0]  comprimento = '0;
  logic [15:0] valor_inicial = '0;
  logic [15:0] passo = '0;
  logic [15:0] dados_saida_ram;
  logic [15:0] dados_entrada_ram;
  logic [5:0]  endereco_ram;
  logic        write_ram;
  logic        ocupado;
  logic        concluido;
  logic [15:0] soma;

  int n_checks = 0;
  int n_fail   = 0;

  // RAM under the sequencer, plus a bench-only load port used during reset.
  logic [15:0] mem [64];
  logic [15:0] golden [64];
  logic        init_we = 1'b0;
  logic [5:0]  init_addr = '0;
  logic [15:0] init_data = '0;

  sequenciador_ram64 dut (
    .clock_principal   (clock_principal),
    .reset             (reset),
    .iniciar           (iniciar),
    .modo              (modo),
    .endereco_base     (endereco_base),
    .comprimento       (comprimento),
    .valor_inicial     (valor_inicial),
    .passo             (passo),
    .dados_saida_ram   (dados_saida_ram),
    .dados_entrada_ram (dados_entrada_ram),
    .endereco_ram      (endereco_ram),
    .write_ram         (write_ram),
    .ocupado           (ocupado),
    .concluido         (concluido),
    .soma              (soma)
  );

  always #5 clock_principal = ~clock_principal;

  always @(posedge clock_principal) begin
    if (init_we) mem[init_addr] <= init_data;
    else if (write_ram) mem[endereco_ram] <= dados_entrada_ram;
  end
  assign dados_saida_ram = mem[endereco_ram];

  task automatic verificar(input string tag, input logic [31:0] obs, input logic [31:0] esp);
    n_checks++;
    if (obs !== esp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, esp);
    end
  endtask

  function automatic int divergencias();
    int d = 0;
    for (int i = 0; i < 64; i++) if (mem[i] !== golden[i]) d++;
    return d;
  endfunction

  task automatic ciclo();
    @(posedge clock_principal);
    #1;
  endtask

  // One full operation: model expectation, drive the start, observe to idle.
  task automatic executar(input int id, input logic m, input logic [5:0] base,
                          input logic [6:0] len, input logic [15:0] v0,
                          input logic [15:0] p, input bit perturbar,
                          output logic [15:0] soma_obs);
    int n, fim, ocup_cnt, wr_cnt, addr;
    logic [15:0] soma_esp;
    n = (len > 7'd64) ? 64 : int'(len);
    soma_esp = '0;
    for (int i = 0; i < n; i++) begin
      addr = (int'(base) + i) % 64;
      if (!m) golden[addr] = 16'(32'(v0) + 32'(i) * 32'(p));
      else    soma_esp = 16'(soma_esp + golden[addr]);
    end
    iniciar = 1'b1; modo = m; endereco_base = base; comprimento = len;
    valor_inicial = v0; passo = p;
    ciclo();
    iniciar = 1'b0;
    // Scramble the arguments to show they were latched at the start edge.
    modo = ~m; endereco_base = 6'($urandom); comprimento = 7'($urandom);
    valor_inicial = 16'($urandom); passo = 16'($urandom);
    fim = 0; ocup_cnt = 0; wr_cnt = 0; soma_obs = '0;
    for (int k = 1; k <= 200 && fim == 0; k++) begin
      iniciar = 1'b0;
      if (ocupado) ocup_cnt++;
      if (write_ram) wr_cnt++;
      if (concluido) begin
        fim = k;
        soma_obs = soma;
        verificar("concl_sem_ocupado", {31'd0, ocupado}, 32'd0);
        verificar("concl_sem_write", {31'd0, write_ram}, 32'd0);
      end else begin
        if (perturbar && k == 3) begin
          iniciar = 1'b1; modo = 1'($urandom);
          comprimento = 7'($urandom_range(1, 64));
        end
        ciclo();
      end
    end
    if (perturbar) begin
      iniciar = 1'b1; modo = 1'b0; comprimento = 7'($urandom_range(1, 64));
    end
    ciclo();
    iniciar = 1'b0;
    verificar("ocioso_pos_fim", {30'd0, ocupado, concluido}, 32'd0);
    ciclo();
    verificar("ocioso_estavel", {30'd0, ocupado, concluido}, 32'd0);
    verificar("soma_mantida", 32'(soma), 32'(soma_esp));
    verificar("latencia", fim, n + 1);
    verificar("ciclos_ocupado", ocup_cnt, n);
    verificar("escritas", wr_cnt, m ? 0 : n);
    verificar("soma", 32'(soma_obs), 32'(soma_esp));
    verificar("ram", divergencias(), 0);
    $display("op %0d modo=%0d base=%0d len=%0d N=%0d v0=0x%04h passo=0x%04h soma=0x%04h lat=%0d",
             id, m, base, len, n, v0, p, soma_obs, fim);
  endtask

  initial begin
    logic [15:0] s;
    int n_wr;
    // Reset with RAM preloaded by random words.
    #1;
    for (int i = 0; i < 64; i++) begin
      init_we = 1'b1; init_addr = 6'(i); init_data = 16'($urandom);
      golden[i] = init_data;
      ciclo();
    end
    init_we = 1'b0;
    verificar("reset_saidas", {dados_entrada_ram, 10'(endereco_ram), write_ram, ocupado, concluido, 3'd0},
              32'd0);
    verificar("reset_soma", 32'(soma), 32'd0);
    @(negedge clock_principal); reset = 1'b0;
    ciclo();
    verificar("idle_pos_reset", {29'd0, write_ram, ocupado, concluido}, 32'd0);

    executar(0, 1'b0, 6'd0, 7'd64, 16'h0100, 16'h0001, 1'b0, s);
    executar(1, 1'b1, 6'd0, 7'd64, 16'h0000, 16'h0000, 1'b0, s);
    verificar("checksum_0x47E0", 32'(s), 32'h47E0);
    executar(2, 1'b0, 6'd60, 7'd8, 16'hA000, 16'h0010, 1'b0, s);
    verificar("wrap_end3", 32'(mem[3]), 32'hA070);
    executar(3, 1'b0, 6'd17, 7'd0, 16'h1234, 16'h0003, 1'b0, s);
    executar(4, 1'b0, 6'd5, 7'd100, 16'h7FFF, 16'hFFFF, 1'b0, s);
    executar(5, 1'b1, 6'd33, 7'd12, 16'h0, 16'h0, 1'b1, s);
    executar(6, 1'b0, 6'd62, 7'd5, 16'hBEEF, 16'h0101, 1'b1, s);
    executar(7, 1'b1, 6'd9, 7'd0, 16'h0, 16'h0, 1'b1, s);

    for (int t = 8; t < 34; t++) begin
      int sel;
      logic [6:0] len;
      sel = $urandom_range(0, 9);
      if (sel == 0)      len = 7'd0;
      else if (sel == 1) len = 7'd64;
      else if (sel == 2) len = 7'($urandom_range(65, 127));
      else               len = 7'($urandom_range(1, 63));
      executar(t, 1'($urandom), 6'($urandom), len, 16'($urandom), 16'($urandom),
               1'($urandom), s);
    end

    // Asynchronous reset after ten words of a full-range fill.
    iniciar = 1'b1; modo = 1'b0; endereco_base = 6'd0; comprimento = 7'd64;
    valor_inicial = 16'h5000; passo = 16'h0003;
    ciclo();
    iniciar = 1'b0;
    n_wr = 0;
    for (int k = 1; k <= 11; k++) begin
      if (k > 1 && write_ram) n_wr++;
      if (k < 11) ciclo();
    end
    for (int i = 0; i < 10; i++) golden[i] = 16'(16'h5000 + i * 3);
    verificar("writes_antes_reset", n_wr, 10);
    verificar("write_antes_reset", {31'd0, write_ram}, 32'd1);
    reset = 1'b1;
    #1;
    verificar("reset_async_write", {31'd0, write_ram}, 32'd0);
    verificar("reset_async_saidas", {dados_entrada_ram, 10'(endereco_ram), write_ram, ocupado, concluido, 3'd0},
              32'd0);
    verificar("reset_async_soma", 32'(soma), 32'd0);
    ciclo();
    ciclo();
    verificar("ram_pos_reset", divergencias(), 0);
    $display("op reset_meio escritas=%0d", n_wr);
    @(negedge clock_principal); reset = 1'b0;
    ciclo();
    executar(99, 1'b1, 6'd0, 7'd64, 16'h0, 16'h0, 1'b0, s);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
